// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/fa_cell.sv
// Single-bit full adder shared by every bit position of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule : fa_cell

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one fa_cell iterated WIDTH times, LSB first.
// Optional subtract mode (sub port, A-B via ~B+1) enabled by SERIAL_ADD_SUB_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]   sum_out_q, sum_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;
  logic               start_ready_q, start_ready_d;
  logic               fa_s, fa_co;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;
  logic [WIDTH-1:0]   sum_shifted;

  // Operand-B and carry values captured on the start handshake
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~b_in : b_in;
  assign carry_load = sub ? 1'b1  : cin;
`else
  assign b_load     = b_in;
  assign carry_load = cin;
`endif

  fa_cell u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign sum_shifted = WIDTH'({fa_s, sum_sh_q} >> 1);

  // Next-state and datapath control
  always_comb begin
    state_d       = state_q;
    a_sh_d        = a_sh_q;
    b_sh_d        = b_sh_q;
    sum_sh_d      = sum_sh_q;
    sum_out_d     = sum_out_q;
    cnt_d         = cnt_q;
    carry_d       = carry_q;
    cout_d        = cout_q;

    case (state_q)
      IDLE: begin
        if (start_valid && start_ready_q) begin
          a_sh_d  = a_in;
          b_sh_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_shifted;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_out_d = sum_shifted;
          cout_d    = fa_co;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the upcoming state
    start_ready_d = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    res_valid_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      a_sh_q        <= '0;
      b_sh_q        <= '0;
      sum_sh_q      <= '0;
      sum_out_q     <= '0;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      cout_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_sh_q        <= a_sh_d;
      b_sh_q        <= b_sh_d;
      sum_sh_q      <= sum_sh_d;
      sum_out_q     <= sum_out_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      cout_q        <= cout_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
      start_ready_q <= start_ready_d;
    end
  end

  assign start_ready = start_ready_q;
  assign sum_out     = sum_out_q;
  assign cout        = cout_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         sub;
  logic [W-1:0] sum_out;
  logic         cout;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  int n_checks;
  int n_fail;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .cin         (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub         (sub),
`endif
    .sum_out     (sum_out),
    .cout        (cout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // One full transaction; hold = cycles res_ready stays low in DONE, poke = mid-run start pulse
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic s, input int hold, input bit poke);
    logic [W:0] ref_v;
    bit         ok;
    int         lat;
    if (s) ref_v = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   ref_v = {1'b0, a} + {1'b0, b} + (W+1)'(ci);

    wait_start_ready(ok);
    check("start_ready_wait", 64'(ok), 64'd1);
    if (!ok) return;

    a_in        = a;
    b_in        = b;
    cin         = ci;
    sub         = s;
    res_ready   = (hold == 0);
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a_in        = W'($urandom);
    b_in        = W'($urandom);
    cin         = 1'($urandom);
    sub         = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    check("start_ready_after_accept", 64'(start_ready), 64'd0);

    lat = 0;
    ok  = 1'b0;
    for (int k = 1; k <= int'(W) + 4; k++) begin
      if (poke && k == 3) begin
        start_valid = 1'b1;
        a_in        = W'(1);
        b_in        = W'(1);
      end
      if (poke && k == 4) start_valid = 1'b0;
      step();
      if (res_valid) begin
        lat = k;
        ok  = 1'b1;
        break;
      end
    end
    start_valid = 1'b0;
    check("latency", 64'(lat), 64'(W));
    if (!ok) return;
    check("sum_out", 64'(sum_out), 64'(ref_v[W-1:0]));
    check("cout", 64'(cout), 64'(ref_v[W]));

    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_res_valid", 64'(res_valid), 64'd1);
      check("hold_sum_out", 64'(sum_out), 64'(ref_v[W-1:0]));
      check("hold_cout", 64'(cout), 64'(ref_v[W]));
      check("hold_start_ready", 64'(start_ready), 64'd0);
    end
    res_ready = 1'b1;
    step();
    check("exit_res_valid", 64'(res_valid), 64'd0);
    check("exit_busy", 64'(busy), 64'd0);
    check("exit_start_ready", 64'(start_ready), 64'd1);
  endtask

  initial begin
    bit ok;
    logic s_r;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    start_valid = 1'b0;
    a_in        = '0;
    b_in        = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    res_ready   = 1'b0;
    step();
    step();
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum_out", 64'(sum_out), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_start_ready", 64'(start_ready), 64'd0);
    rst = 1'b0;
    step();
    check("idle_start_ready", 64'(start_ready), 64'd1);

    run_op(8'h5A, 8'h33, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    run_op(8'h5A, 8'h33, 1'b1, 1'b0, 5, 1'b0);
    run_op(8'hC3, 8'h2E, 1'b0, 1'b0, 0, 1'b1);

    // Reset in the middle of a run
    wait_start_ready(ok);
    check("rst_mid_ready_wait", 64'(ok), 64'd1);
    a_in        = 8'hAB;
    b_in        = 8'h77;
    cin         = 1'b1;
    res_ready   = 1'b1;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_mid_res_valid", 64'(res_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_sum_out", 64'(sum_out), 64'd0);
    check("rst_mid_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0);
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      s_r = 1'($urandom);
`else
      s_r = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), s_r,
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
